// File: rtl/nf10_router_output_queues_if.sv
// AXI4-Stream bundle used on both sides of the router output queues.
// N lanes share one interface: lane i occupies slice i of every vector.
//   master: drives tdata/tstrb/tuser/tvalid/tlast, samples tready
//   slave : samples tdata/tstrb/tuser/tvalid/tlast, drives tready
interface nf10_router_output_queues_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128,
  parameter int N      = 1
);
  logic [N*DATA_W-1:0]   tdata;
  logic [N*DATA_W/8-1:0] tstrb;
  logic [N*USER_W-1:0]   tuser;
  logic [N-1:0]          tvalid;
  logic [N-1:0]          tlast;
  logic [N-1:0]          tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input  tready);
  modport slave  (input  tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_router_output_queues.sv
// Router output queues: splits the post-lookup AXI4-Stream into one
// first-word-fall-through FIFO per destination port (even mask bits are MAC
// ports, odd bits are CPU DMA ports). Admission is decided once per packet on
// its first word; a queue that cannot hold a maximum-size packet gets nothing.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   s_axis (slave) : single-lane input stream, TUSER carries the dest mask
//   m_axis (master): NUM_PORTS-lane output stream, lane i = queue i
//   o_pkt_stored   : per-queue pulse in the admission cycle when accepted
//   o_pkt_dropped  : per-queue pulse when a requested queue lacks room
//   o_pkt_no_dst   : pulse when a packet carries an all-zero dest mask
module nf10_router_output_queues #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS         = 24,
  parameter int NUM_PORTS            = 8,
  parameter int QUEUE_DEPTH_BITS     = 6,
  parameter int MAX_PKT_WORDS        = 48
) (
  input  logic                        clk,
  input  logic                        reset,
  nf10_router_output_queues_if.slave  s_axis,
  nf10_router_output_queues_if.master m_axis,
  output logic [NUM_PORTS-1:0]        o_pkt_stored,
  output logic [NUM_PORTS-1:0]        o_pkt_dropped,
  output logic                        o_pkt_no_dst
);
  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int SW     = DW / 8;
  localparam int WORD_W = 1 + UW + SW + DW;
  localparam int DEPTH  = 1 << QUEUE_DEPTH_BITS;

  typedef logic [QUEUE_DEPTH_BITS-1:0] ptr_t;
  // One extra bit so a completely full queue is distinguishable from empty.
  typedef logic [QUEUE_DEPTH_BITS:0]   cnt_t;

  localparam cnt_t ROOM_LIMIT = cnt_t'(DEPTH - MAX_PKT_WORDS);
  localparam cnt_t CNT_ONE    = cnt_t'(1);
  localparam ptr_t PTR_ONE    = ptr_t'(1);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic                 tready_q, tready_d;

  logic [NUM_PORTS-1:0] dst_field, room, push, pop, stored, dropped;
  logic                 no_dst;
  logic [WORD_W-1:0]    in_word;

  logic [WORD_W-1:0] mem_q [NUM_PORTS][DEPTH];
  ptr_t wr_ptr_q [NUM_PORTS];
  ptr_t wr_ptr_d [NUM_PORTS];
  ptr_t rd_ptr_q [NUM_PORTS];
  ptr_t rd_ptr_d [NUM_PORTS];
  cnt_t used_q   [NUM_PORTS];
  cnt_t used_d   [NUM_PORTS];

  assign dst_field     = s_axis.tuser[DST_PORT_POS +: NUM_PORTS];
  assign in_word       = {s_axis.tlast[0], s_axis.tuser, s_axis.tstrb, s_axis.tdata};
  assign s_axis.tready = tready_q;

  // A queue may take a new packet only if a maximum-size packet still fits.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      room[i] = (used_q[i] <= ROOM_LIMIT);
    end
  end

  // Input FSM. TREADY stays low in IDLE so the first word (and its TUSER)
  // can be inspected without being consumed; that costs one bubble/packet.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    mask_d   = mask_q;
    push     = '0;
    stored   = '0;
    dropped  = '0;
    no_dst   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_axis.tvalid[0]) begin
          stored  = dst_field & room;
          dropped = dst_field & ~room;
          no_dst  = (dst_field == '0);
          mask_d  = dst_field & room;
          state_d = (|(dst_field & room)) ? WRITE : DROP;
        end
      end
      WRITE: begin
        // tready_q is high in every non-IDLE state, so TVALID is the handshake.
        if (s_axis.tvalid[0]) begin
          push = mask_q;
          if (s_axis.tlast[0]) state_d = IDLE;
        end
      end
      DROP: begin
        if (s_axis.tvalid[0] && s_axis.tlast[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tready_d = (state_d != IDLE);
  end

  // Decision pulses belong to the IDLE cycle in which the first word is seen.
  assign o_pkt_stored  = reset ? '0   : stored;
  assign o_pkt_dropped = reset ? '0   : dropped;
  assign o_pkt_no_dst  = reset ? 1'b0 : no_dst;

  // Per-queue pointer and occupancy bookkeeping.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      pop[i]      = (used_q[i] != '0) && m_axis.tready[i];
      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_ONE : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_ONE : rd_ptr_q[i];
      unique case ({push[i], pop[i]})
        2'b10:   used_d[i] = used_q[i] + CNT_ONE;
        2'b01:   used_d[i] = used_q[i] - CNT_ONE;
        default: used_d[i] = used_q[i];
      endcase
    end
  end

  // First-word fall-through: the head entry is always on the bus.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      m_axis.tvalid[i]          = (used_q[i] != '0);
      m_axis.tlast[i]           = (used_q[i] != '0) && mem_q[i][rd_ptr_q[i]][WORD_W-1];
      m_axis.tuser[i*UW +: UW]  = mem_q[i][rd_ptr_q[i]][SW+DW +: UW];
      m_axis.tstrb[i*SW +: SW]  = mem_q[i][rd_ptr_q[i]][DW +: SW];
      m_axis.tdata[i*DW +: DW]  = mem_q[i][rd_ptr_q[i]][0 +: DW];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      tready_q <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        used_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      tready_q <= tready_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        used_q[i]   <= used_d[i];
      end
    end
  end

  // NOTE: queue storage is not reset; emptiness is tracked by used_q, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_word;
    end
  end
endmodule

// File: tb/tb_nf10_router_output_queues.sv
// Bench for nf10_router_output_queues: directed scenarios followed by random
// packets, checked against a packet-level model (per-queue expected word
// lists; occupancy = words admitted minus words seen leaving).
module tb_nf10_router_output_queues;
  localparam int DW    = 256;
  localparam int UW    = 128;
  localparam int SW    = DW / 8;
  localparam int NP    = 8;
  localparam int DPOS  = 24;
  localparam int QDB   = 6;
  localparam int MAXW  = 48;
  localparam int ROOM  = (1 << QDB) - MAXW;
  localparam int WW    = 1 + UW + SW + DW;

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } word_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [NP-1:0] o_pkt_stored, o_pkt_dropped;
  logic          o_pkt_no_dst;

  int total = 0, bad = 0, cyc = 0, present_cyc = 0, rdy_mode = 0;
  word_t pkt[$];
  word_t exp_q[NP][$];
  word_t got_q[NP][$];
  int got_base[NP] = '{default: 0};
  int vcount[NP]   = '{default: 0};
  int rise_cyc[NP] = '{default: -1};
  logic [NP-1:0] prev_v = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nf10_router_output_queues_if #(.DATA_W(DW), .USER_W(UW), .N(1))  s_if ();
  nf10_router_output_queues_if #(.DATA_W(DW), .USER_W(UW), .N(NP)) m_if ();

  nf10_router_output_queues #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .DST_PORT_POS(DPOS),
    .NUM_PORTS(NP), .QUEUE_DEPTH_BITS(QDB), .MAX_PKT_WORDS(MAXW)
  ) dut (
    .clk(clk), .reset(reset), .s_axis(s_if), .m_axis(m_if),
    .o_pkt_stored(o_pkt_stored), .o_pkt_dropped(o_pkt_dropped), .o_pkt_no_dst(o_pkt_no_dst)
  );

  task automatic check_v(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic check_w(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Output monitor: records every word handed over on each lane.
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (m_if.tvalid[i] === 1'b1) begin
        vcount[i]++;
        if (!prev_v[i]) rise_cyc[i] = cyc;
      end
      prev_v[i] = (m_if.tvalid[i] === 1'b1);
      if (m_if.tvalid[i] === 1'b1 && m_if.tready[i] === 1'b1)
        got_q[i].push_back({m_if.tlast[i], m_if.tuser[i*UW +: UW],
                            m_if.tstrb[i*SW +: SW], m_if.tdata[i*DW +: DW]});
    end
  end

  // Output back-pressure: 0 all ready, 1 random, 2 port 0 stalled, 3 none ready.
  initial begin
    m_if.tready = '0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_if.tready = '1;
        1:       m_if.tready = NP'($urandom);
        2:       m_if.tready = {{(NP-1){1'b1}}, 1'b0};
        default: m_if.tready = '0;
      endcase
    end
  end

  function automatic void make_pkt(input logic [NP-1:0] dst, input int len);
    word_t w;
    pkt.delete();
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < DW/32; j++) w.data[j*32 +: 32] = $urandom;
      for (int j = 0; j < UW/32; j++) w.user[j*32 +: 32] = $urandom;
      w.strb             = $urandom;
      w.user[DPOS +: NP] = dst;
      w.last             = (k == len - 1);
      pkt.push_back(w);
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < NP; i++) begin
      exp_q[i].delete();
      got_base[i] = got_q[i].size();
    end
  endfunction

  // Sends the first nwords of pkt. Entered and left at posedge+1.
  task automatic send_pkt(input int nwords);
    logic [NP-1:0] dst, room, mask;
    bit acc;
    int waited, used;
    dst = pkt[0].user[DPOS +: NP];
    for (int i = 0; i < NP; i++) begin
      used    = exp_q[i].size() - (got_q[i].size() - got_base[i]);
      room[i] = (used <= ROOM);
    end
    mask        = dst & room;
    present_cyc = cyc;
    for (int k = 0; k < nwords; k++) begin
      s_if.tvalid = 1'b1;
      {s_if.tlast, s_if.tuser, s_if.tstrb, s_if.tdata} = pkt[k];
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 8) begin
        @(negedge clk);
        if (k == 0 && waited == 0) begin
          check_v("idle_tready",   32'(s_if.tready), 32'd0);
          check_v("pkt_stored",    32'(o_pkt_stored), 32'(mask));
          check_v("pkt_dropped",   32'(o_pkt_dropped), 32'(dst & ~room));
          check_v("pkt_no_dst",    32'(o_pkt_no_dst), 32'(dst == '0));
        end else if (k == 0 && waited == 1) begin
          check_v("pulse_width", 32'({o_pkt_stored, o_pkt_dropped, o_pkt_no_dst}), 32'd0);
        end
        acc = (s_if.tready[0] === 1'b1);
        if (acc) for (int i = 0; i < NP; i++) if (mask[i]) exp_q[i].push_back(pkt[k]);
        @(posedge clk); #1;
        waited++;
      end
      check_v("accept_in_time", 32'(acc), 32'd1);
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain_and_compare();
    bit done = 1'b0;
    int n;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      done = 1'b1;
      for (int i = 0; i < NP; i++)
        if (got_q[i].size() - got_base[i] != exp_q[i].size()) done = 1'b0;
    end
    check_v("drain_in_time", 32'(done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      n = got_q[i].size() - got_base[i];
      check_v($sformatf("word_count_p%0d", i), 32'(n), 32'(exp_q[i].size()));
      for (int k = 0; k < n && k < exp_q[i].size(); k++)
        check_w($sformatf("word_p%0d_%0d", i, k), got_q[i][got_base[i] + k], exp_q[i][k]);
    end
    clear_model();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vsnap[NP];
    logic [NP-1:0] nonempty, rdst;
    int rlen;

    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    s_if.tstrb  = '0;
    s_if.tdata  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_v("rst_s_tready", 32'(s_if.tready), 32'd0);
    check_v("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check_v("rst_m_tlast",  32'(m_if.tlast),  32'd0);
    check_v("rst_pulses",   32'({o_pkt_stored, o_pkt_dropped, o_pkt_no_dst}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 3-word packet to port 0, latency and isolation.
    vsnap = vcount;
    make_pkt(8'h01, 3);
    send_pkt(3);
    drain_and_compare();
    check_v("latency_p0", 32'(rise_cyc[0] - present_cyc), 32'd2);
    for (int i = 1; i < NP; i++)
      check_v($sformatf("quiet_p%0d", i), 32'(vcount[i] - vsnap[i]), 32'd0);

    // Multicast to MAC0 and MAC1.
    make_pkt(8'h05, 4);
    send_pkt(4);
    drain_and_compare();

    // No destination: consumed and discarded.
    vsnap = vcount;
    make_pkt(8'h00, 3);
    send_pkt(3);
    drain_and_compare();
    for (int i = 0; i < NP; i++)
      check_v($sformatf("nodst_quiet_p%0d", i), 32'(vcount[i] - vsnap[i]), 32'd0);

    // Fill port 0 with a maximum packet, next one must be dropped.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    make_pkt(8'h01, MAXW);
    send_pkt(MAXW);
    make_pkt(8'h01, 1);
    send_pkt(1);
    check_v("p0_held", 32'(got_q[0].size() - got_base[0]), 32'd0);
    rdy_mode = 0;
    drain_and_compare();

    // First word presented while the block is held in reset.
    make_pkt(8'h08, 5);
    reset = 1'b1;
    s_if.tvalid = 1'b1;
    {s_if.tlast, s_if.tuser, s_if.tstrb, s_if.tdata} = pkt[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_v("stall_tready", 32'(s_if.tready), 32'd0);
      check_v("stall_pulses", 32'({o_pkt_stored, o_pkt_dropped, o_pkt_no_dst}), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    clear_model();
    send_pkt(5);
    drain_and_compare();

    // Reset in the middle of a 10-word packet.
    rdy_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    make_pkt(8'h02, 10);
    send_pkt(4);
    for (int i = 0; i < NP; i++) nonempty[i] = (exp_q[i].size() != 0);
    reset = 1'b1;
    @(negedge clk);
    check_v("pre_reset_valid", 32'(m_if.tvalid), 32'(nonempty));
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    check_v("post_reset_valid",  32'(m_if.tvalid), 32'd0);
    check_v("post_reset_tready", 32'(s_if.tready), 32'd0);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    make_pkt(8'h02, 10);
    send_pkt(10);
    drain_and_compare();

    // Random traffic with random back-pressure.
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      rdst = ($urandom_range(0, 7) == 0) ? '0 : NP'($urandom);
      rlen = ($urandom_range(0, 4) == 0) ? MAXW : $urandom_range(1, 8);
      make_pkt(rdst, rlen);
      send_pkt(rlen);
    end
    rdy_mode = 0;
    drain_and_compare();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
